// File: rtl/mem_pkg.sv
// Shared types for the LEGv8 memory stage: pipeline register layouts and
// the data-memory controller state encoding.
package mem_pkg;

  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  zero;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     write_data;
    logic [DATA_W-1:0]     pc_branch;
  } ex_mem_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  bus_err;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     read_data;
  } mem_wb_t;

  function automatic logic is_memop(input logic valid, input logic rd, input logic wr);
    return valid & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Data-memory request/acknowledge controller with a bounded wait window.
//   state | meaning
//   IDLE  | no access outstanding, or an access completing this cycle
//   WAIT  | request issued in an earlier cycle, still waiting for dm_ack
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic memop,
  input  logic dm_ack,
  output logic dm_req,
  output logic stall,
  output logic abort
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    case (state)
      IDLE: begin
        if (dm_req && !dm_ack) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT: begin
        // a dropped memop only happens across reset, but never strand the FSM
        if (!memop || dm_ack || abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = wait_cnt + 1'b1;
        end
      end
    endcase
  end

  // abort uses memop rather than dm_req to avoid a combinational loop
  always_comb begin
    abort  = (state == WAIT) && (wait_cnt == CNT_LAST) && !dm_ack && memop;
    dm_req = memop & ~abort;
    stall  = memop & ~dm_ack & ~abort;
  end

endmodule

// File: rtl/mem_stage.sv
// LEGv8 memory stage: EX/MEM register, branch resolution, data-memory
// access control with timeout, and the MEM/WB register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int N       = DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_E,
  input  logic                  flush_E,
  input  logic [N-1:0]          aluResult_E,
  input  logic [N-1:0]          writeData_E,
  input  logic [N-1:0]          PCBranch_E,
  input  logic                  zero_E,
  input  logic                  MemRead_E,
  input  logic                  MemWrite_E,
  input  logic                  Branch_E,
  input  logic                  RegWrite_E,
  input  logic                  MemtoReg_E,
  input  logic [REG_ADDR_W-1:0] rd_E,
  output logic [N-1:0]          dm_addr,
  output logic [N-1:0]          dm_wdata,
  output logic                  dm_req,
  output logic                  dm_we,
  input  logic [N-1:0]          dm_rdata,
  input  logic                  dm_ack,
  output logic                  PCSrc_M,
  output logic [N-1:0]          PCBranch_M,
  output logic                  stall_M,
  output logic [N-1:0]          readData_W,
  output logic [N-1:0]          aluResult_W,
  output logic [REG_ADDR_W-1:0] rd_W,
  output logic                  RegWrite_W,
  output logic                  MemtoReg_W,
  output logic                  valid_W,
  output logic                  bus_err_W
);

  ex_mem_t m_q;
  mem_wb_t w_q;
  logic    memop_m;
  logic    abort;
  logic    advance;
  logic    ack_ok;

  assign memop_m = is_memop(m_q.valid, m_q.mem_read, m_q.mem_write);

  mem_ctrl #(.TIMEOUT(TIMEOUT)) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .memop  (memop_m),
    .dm_ack (dm_ack),
    .dm_req (dm_req),
    .stall  (stall_M),
    .abort  (abort)
  );

  assign advance = ~stall_M;
  // an ack with no request outstanding carries no data
  assign ack_ok  = dm_ack & dm_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
    end else if (advance) begin
      m_q.valid      <= valid_E & ~flush_E;
      m_q.mem_read   <= MemRead_E;
      m_q.mem_write  <= MemWrite_E;
      m_q.branch     <= Branch_E;
      m_q.reg_write  <= RegWrite_E;
      m_q.mem_to_reg <= MemtoReg_E;
      m_q.zero       <= zero_E;
      m_q.rd         <= rd_E;
      m_q.alu_result <= aluResult_E;
      m_q.write_data <= writeData_E;
      m_q.pc_branch  <= PCBranch_E;
    end
  end

  assign dm_we      = m_q.valid & m_q.mem_write;
  assign dm_addr    = m_q.alu_result;
  assign dm_wdata   = m_q.write_data;
  assign PCSrc_M    = m_q.valid & m_q.branch & m_q.zero;
  assign PCBranch_M = m_q.pc_branch;

  // a stalled M stage feeds a bubble into W; data fields simply hold
  always_ff @(posedge clk) begin
    if (reset) begin
      w_q <= '0;
    end else if (advance) begin
      w_q.valid      <= m_q.valid;
      w_q.reg_write  <= m_q.reg_write & m_q.valid & ~abort;
      w_q.mem_to_reg <= m_q.mem_to_reg;
      w_q.rd         <= m_q.rd;
      w_q.alu_result <= m_q.alu_result;
      w_q.read_data  <= (m_q.mem_read && ack_ok) ? dm_rdata : '0;
      w_q.bus_err    <= abort;
    end else begin
      w_q.valid     <= 1'b0;
      w_q.reg_write <= 1'b0;
      w_q.bus_err   <= 1'b0;
    end
  end

  assign valid_W     = w_q.valid;
  assign RegWrite_W  = w_q.reg_write;
  assign MemtoReg_W  = w_q.mem_to_reg;
  assign bus_err_W   = w_q.bus_err;
  assign rd_W        = w_q.rd;
  assign aluResult_W = w_q.alu_result;
  assign readData_W  = w_q.read_data;

endmodule
